// File: rtl/seg_display_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner.
package seg_scan_pkg;

    // Scan sequencer phases: all-off blanking gap, or a digit being driven.
    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    // Segment pattern with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment codes {g,f,e,d,c,b,a} for BCD 0..9; element [n] is digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : seg_scan_pkg

// File: rtl/seg_display_scanner_decoder.sv
// BCD to seven-segment decoder; codes above 9 decode to all-off.
module seven_segment_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for legal BCD codes, blank for the six illegal ones.
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule : seven_segment_decoder

// File: rtl/seg_display_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with a frame-aligned
// shadow register, blanking gaps and leading-zero suppression.
module seg_display_scanner
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);

    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_digit_idx;
    logic [4*NUM_DIGITS-1:0]   r_active;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic                      r_pending;
    logic [NUM_DIGITS-1:0]     r_an;
    logic [6:0]                r_seg;
    logic                      r_frame_done;

    scan_state_t               w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      w_frame_start;
    logic                      w_commit;
    logic                      w_transfer;
    logic [4*NUM_DIGITS-1:0]   w_active_nxt;
    logic [3:0]                w_digit;
    logic [6:0]                w_dec_seg;
    logic [NUM_DIGITS-1:0]     w_zero_above;
    logic                      w_suppress;
    logic [NUM_DIGITS-1:0]     w_an_nxt;
    logic [6:0]                w_seg_nxt;

    assign in_ready   = !r_pending;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

    assign w_transfer   = in_valid && !r_pending;
    assign w_commit     = w_frame_start && r_pending;
    // The value shown from this edge on: the shadow wins at a committing boundary.
    assign w_active_nxt = w_commit ? r_shadow : r_active;

    // Scan sequencer next state; a low enable parks it in its reset position.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_idx_nxt     = r_digit_idx;
        w_frame_start = 1'b0;
        if (!enable) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = '0;
            w_idx_nxt   = IDX_LAST;
        end else begin
            case (r_state)
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                        if (r_digit_idx == IDX_LAST) begin
                            w_idx_nxt     = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_nxt = r_digit_idx + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Pick the digit that will be on the pads after this edge.
    assign w_digit = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];

    seven_segment_decoder u_decoder (
        .bcd (w_digit),
        .seg (w_dec_seg)
    );

    // For each digit, flag whether it and every more-significant digit are zero;
    // illegal codes are nonzero and so stop the suppression run.
    always_comb begin
        logic v_zero;
        v_zero       = 1'b1;
        w_zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_zero          = v_zero && (w_active_nxt[4*i +: 4] == 4'd0);
            w_zero_above[i] = v_zero;
        end
    end

    assign w_suppress = lz_en && (w_idx_nxt != '0) && w_zero_above[w_idx_nxt];

    // Output pattern for the coming cycle; digit enable stays on when masked.
    always_comb begin
        w_an_nxt  = '0;
        w_seg_nxt = SEG_BLANK;
        if (w_state_nxt == SHOW) begin
            w_an_nxt = NUM_DIGITS'(1) << w_idx_nxt;
            if ((w_digit <= 4'd9) && !w_suppress) begin
                w_seg_nxt = w_dec_seg;
            end
        end
    end

    // Sequencer state and registered pad outputs.
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= GAP;
            r_cnt        <= '0;
            r_digit_idx  <= IDX_LAST;
            r_an         <= '0;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit_idx  <= w_idx_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_start;
        end
    end

    // Input handshake, shadow buffer and frame-aligned commit.
    // NOTE: the shadow is a plain register, not a memory, so it is reset too;
    // a reset must discard any buffered value anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (w_transfer) begin
                r_shadow  <= value_in;
                r_pending <= 1'b1;
            end
        end
    end

endmodule : seg_display_scanner
